// File: rtl/tmrx_pkg.sv
// Shared definitions for the TMRX error-sink aggregator: clear FSM state
// encoding and the default channel count / counter width.
package tmrx_pkg;

  localparam int TMRX_NUM_CH_DEFAULT = 4;
  localparam int TMRX_CNT_W_DEFAULT  = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

endpackage : tmrx_pkg

// File: rtl/tmrx_err_chan.sv
// One error channel: rising-edge detect on the raw error level, a sticky
// flag and (when TMRX_ERR_CNT_EN is defined) a saturating event counter.
// A new event always beats a clear applied in the same cycle.
module tmrx_err_chan
  import tmrx_pkg::*;
#(
  parameter int CNT_W = TMRX_CNT_W_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             err_i,
  input  logic             ev_clr,     // latched clear-mask bit for this channel
  input  logic             clr_apply,  // clear FSM is applying the mask this cycle
  output logic             sticky_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic err_q;
  logic sticky_q, sticky_d;
  logic ev;
  logic clr;

  assign ev  = err_i & ~err_q;
  assign clr = ev_clr & clr_apply;

  // Sticky next state: event sets, clear resets, event wins.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    sticky_d = sticky_q;
    if (ev) begin
      sticky_d = 1'b1;
    end else if (clr) begin
      sticky_d = 1'b0;
    end
  end

  // Edge-detect history and sticky flag registers.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every register samples the
    // pre-edge values of the others, independent of statement order.
    if (rst_i) begin
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      err_q    <= err_i;
      sticky_q <= sticky_d;
    end
  end

  assign sticky_o = sticky_q;

`ifdef TMRX_ERR_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter next state: saturating increment, an event coinciding with a
  // clear restarts the count at one.
  always_comb begin
    cnt_d = cnt_q;
    if (ev) begin
      if (clr) begin
        cnt_d = CNT_W'(1);
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (clr) begin
      cnt_d = '0;
    end
  end

  // Event counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
`else
  assign cnt_o = '0;
`endif

endmodule : tmrx_err_chan

// File: rtl/tmrx_err_aggregator.sv
// TMRX error-sink aggregator top. Instantiates one tmrx_err_chan per
// channel and holds the clear handshake FSM, the clear-mask latch, the
// counter readout mux and the combined error-sink output.
// Optional feature macro: TMRX_ERR_CNT_EN (per-channel event counters).
module tmrx_err_aggregator
  import tmrx_pkg::*;
#(
  parameter int NUM_CH = TMRX_NUM_CH_DEFAULT,
  parameter int CNT_W  = TMRX_CNT_W_DEFAULT,
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_CH-1:0] err_i,
  input  logic              clr_valid_i,
  input  logic [NUM_CH-1:0] clr_mask_i,
  output logic              clr_ready_o,
  output logic [NUM_CH-1:0] sticky_o,
  input  logic [SEL_W-1:0]  cnt_sel_i,
  output logic [CNT_W-1:0]  cnt_o,
  (* tmrx_error_sink *)
  output logic              err_o
);

  clr_state_e                   state_q, state_d;
  logic [NUM_CH-1:0]            mask_q, mask_d;
  logic                         clr_apply;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_w;

  // Clear handshake: accept in IDLE, apply the latched mask for one cycle.
  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    clr_ready_o = 1'b0;
    clr_apply   = 1'b0;
    case (state_q)
      IDLE: begin
        clr_ready_o = 1'b1;
        if (clr_valid_i) begin
          state_d = CLEAR;
          mask_d  = clr_mask_i;
        end
      end
      CLEAR: begin
        clr_apply = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and clear-mask latch; reset discards any pending clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
    tmrx_err_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .err_i    (err_i[k]),
      .ev_clr   (mask_q[k]),
      .clr_apply(clr_apply),
      .sticky_o (sticky_o[k]),
      .cnt_o    (cnt_w[k])
    );
  end

  assign err_o = |sticky_o;

`ifdef TMRX_ERR_CNT_EN
  // Counter readout; selections beyond the last channel read zero.
  always_comb begin
    cnt_o = '0;
    if (32'(cnt_sel_i) < NUM_CH) begin
      cnt_o = cnt_w[cnt_sel_i];
    end
  end
`else
  logic unused_sel;
  assign unused_sel = ^{cnt_sel_i, cnt_w};
  assign cnt_o      = '0;
`endif

endmodule : tmrx_err_aggregator
